quant_sched: RTL and testbench
==============================

Name: quant_sched

Overview:
- Sequencing and configuration controller in front of the quantization shifter.
- Accepts transposed DCT coefficient pairs over a valid/ready handshake and tracks their position within the 8x8 block (32 pairs per block).
- Attaches the per-coefficient right-shift amounts, read from a runtime-programmable, double-buffered 64-entry shift table, and flags the last pair of each block.
- Provides one registered output stage with backpressure, so the downstream shifter can stall.

Parameters:
- DATA_WIDTH, 25: coefficient width (signed).
- SHIFT_WIDTH, 5: width of each shift-table entry.
- DEFAULT_SHIFT, 18: value loaded into every entry of both banks at reset.
- BLK_CNT_WIDTH, 16: width of the completed-block counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_c0, i_c1  in  DATA_WIDTH  signed coefficient pair; c0 is at index n, c1 at index n+1.
- i_vld  in  1  input pair valid.
- o_rdy  out  1  upstream ready.
- o_c0, o_c1  out  DATA_WIDTH  registered coefficient pair.
- o_sh0, o_sh1  out  SHIFT_WIDTH  shift amounts for o_c0 and o_c1.
- o_idx  out  6  block index of o_c0 (always even).
- o_last  out  1  output pair is indices 62/63.
- o_vld  out  1  output valid.
- i_rdy  in  1  downstream ready.
- i_cfg_we  in  1  shadow-table write strobe.
- i_cfg_addr  in  6  shadow-table entry address.
- i_cfg_data  in  SHIFT_WIDTH  shadow-table write data.
- i_cfg_swap  in  1  one-cycle request to make the shadow bank active.
- o_cfg_busy  out  1  a swap is pending.
- o_bank  out  1  index of the active bank.
- o_blk_cnt  out  BLK_CNT_WIDTH  blocks completed; wraps at 2^BLK_CNT_WIDTH.

Behaviour:
- Reset (i_reset high at a clock edge):
  - o_vld=0, o_last=0, o_c0/o_c1=0, o_sh0/o_sh1=0, o_idx=0.
  - o_bank=0, o_cfg_busy=0, o_blk_cnt=0, pair counter=0.
  - All 128 table entries are set to DEFAULT_SHIFT.
  - Reset mid-block discards the partial block and any pending swap.
- Handshake:
  - o_rdy = ~o_vld | i_rdy (combinational).
  - Input accept = i_vld & o_rdy. Output transfer = o_vld & i_rdy.
- Latency:
  - Accept at edge k gives o_vld=1 after edge k with the data registered.
  - While o_vld=1 and i_rdy=0, all output registers hold.
  - o_vld clears after a transfer with no simultaneous accept.
  - Back-to-back throughput is one pair per clock.
- Sequencing:
  - The pair counter p (0..31) increments on accept and wraps 31→0.
  - On accept: o_idx=2p, o_sh0=active[2p], o_sh1=active[2p+1], o_last=(p==31).
  - o_blk_cnt increments on the accept of p==31.
- State machine:
  - IDLE (p==0, no block in progress): first accept → RUN.
  - RUN: accept with p==31 → IDLE, or SWAP if a swap is pending.
  - SWAP (one cycle, o_rdy forced 0): toggle o_bank, clear o_cfg_busy, → IDLE.
  - A swap requested while in IDLE with no accept that cycle sets pending; the next cycle is SWAP.
- Config rules:
  - Writes always target the shadow bank (~o_bank).
  - Writes are ignored while o_cfg_busy=1 or in SWAP.
  - i_cfg_swap while already busy has no extra effect.
  - i_cfg_swap on the same cycle as the p==31 accept is honoured: the next state is SWAP.
  - i_cfg_we and i_cfg_swap together: the write lands in the current shadow bank, then the swap is pended.
- Arithmetic: the coefficients pass through unmodified. The block performs no shifting.

Optional Feature:
- Macro QUANT_SCHED_PERF_EN.
- Defined: adds output o_stall_cnt (16 bits), which counts cycles with o_vld & ~i_rdy. It saturates at 0xFFFF and is cleared by reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then 32 back-to-back pairs (c0=2n, c1=2n+1) with i_rdy=1:
  - o_vld one cycle after the first accept.
  - o_idx runs 0,2,…,62.
  - All o_sh = 18.
  - o_last only on idx 62.
  - o_blk_cnt=1.
- Write shadow entries addr0=3 and addr1=4, pulse swap while idle:
  - o_cfg_busy=1 for one cycle, o_rdy=0 during SWAP, then o_bank=1.
  - The next block's first pair has o_sh0=3, o_sh1=4.
- Pulse swap at pair p=10:
  - The rest of the block keeps old shifts.
  - SWAP follows the p==31 accept.
  - A write attempted while busy leaves the table unchanged.
- Hold i_rdy=0 for 5 cycles mid-stream:
  - Outputs stable, o_rdy=0, no pair lost or duplicated.
  - With QUANT_SCHED_PERF_EN, o_stall_cnt=5.
- Assert i_reset at pair p=20:
  - Next cycle o_vld=0 and o_bank=0.
  - The following input gets o_idx=0 and o_sh=18.
- Run 65536 blocks (or force the counter to 0xFFFF): o_blk_cnt wraps to 0.

Source files
------------

// File: rtl/quant_sched.sv
// quant_sched: sequences DCT coefficient pairs and attaches per-index shifts from a double-buffered table.
// Optional define QUANT_SCHED_PERF_EN adds the o_stall_cnt output-stall counter.
module quant_sched #(
  parameter int DATA_WIDTH    = 25,
  parameter int SHIFT_WIDTH   = 5,
  parameter int DEFAULT_SHIFT = 18,
  parameter int BLK_CNT_WIDTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic signed [DATA_WIDTH-1:0]    i_c0,
  input  logic signed [DATA_WIDTH-1:0]    i_c1,
  input  logic                            i_vld,
  output logic                            o_rdy,
  output logic signed [DATA_WIDTH-1:0]    o_c0,
  output logic signed [DATA_WIDTH-1:0]    o_c1,
  output logic        [SHIFT_WIDTH-1:0]   o_sh0,
  output logic        [SHIFT_WIDTH-1:0]   o_sh1,
  output logic        [5:0]               o_idx,
  output logic                            o_last,
  output logic                            o_vld,
  input  logic                            i_rdy,
  input  logic                            i_cfg_we,
  input  logic        [5:0]               i_cfg_addr,
  input  logic        [SHIFT_WIDTH-1:0]   i_cfg_data,
  input  logic                            i_cfg_swap,
  output logic                            o_cfg_busy,
  output logic                            o_bank,
`ifdef QUANT_SCHED_PERF_EN
  output logic        [15:0]              o_stall_cnt,
`endif
  output logic        [BLK_CNT_WIDTH-1:0] o_blk_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SWAP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [SHIFT_WIDTH-1:0]   r_tab0 [64];
  logic [SHIFT_WIDTH-1:0]   r_tab1 [64];
  logic [4:0]               r_p;
  logic                     r_bank;
  logic                     r_busy;
  logic [BLK_CNT_WIDTH-1:0] r_blk;

  logic signed [DATA_WIDTH-1:0] r_c0;
  logic signed [DATA_WIDTH-1:0] r_c1;
  logic [SHIFT_WIDTH-1:0]       r_sh0;
  logic [SHIFT_WIDTH-1:0]       r_sh1;
  logic [5:0]                   r_idx;
  logic                         r_last;
  logic                         r_vld;

  logic                   w_swap_st;
  logic                   w_rdy;
  logic                   w_acc;
  logic                   w_lastp;
  logic                   w_wr;
  logic [5:0]             w_i0;
  logic [5:0]             w_i1;
  logic [SHIFT_WIDTH-1:0] w_sh0;
  logic [SHIFT_WIDTH-1:0] w_sh1;

  assign w_swap_st = (r_state == S_SWAP);
  assign w_rdy     = (~r_vld | i_rdy) & ~w_swap_st;
  assign w_acc     = i_vld & w_rdy;
  assign w_lastp   = (r_p == 5'd31);
  assign w_wr      = i_cfg_we & ~r_busy & ~w_swap_st;
  assign w_i0      = {r_p, 1'b0};
  assign w_i1      = {r_p, 1'b1};
  assign w_sh0     = r_bank ? r_tab1[w_i0] : r_tab0[w_i0];
  assign w_sh1     = r_bank ? r_tab1[w_i1] : r_tab0[w_i1];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc)                    w_nxt = S_RUN;
        else if (r_busy | i_cfg_swap) w_nxt = S_SWAP;
      end
      S_RUN: begin
        if (w_acc & w_lastp)
          w_nxt = (r_busy | i_cfg_swap) ? S_SWAP : S_IDLE;
      end
      S_SWAP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // writes always go to the bank not currently feeding the datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 64; i++) begin
        r_tab0[i] <= SHIFT_WIDTH'(DEFAULT_SHIFT);
        r_tab1[i] <= SHIFT_WIDTH'(DEFAULT_SHIFT);
      end
    end else if (w_wr) begin
      if (r_bank) r_tab0[i_cfg_addr] <= i_cfg_data;
      else        r_tab1[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bank <= 1'b0;
      r_busy <= 1'b0;
      r_p    <= '0;
      r_blk  <= '0;
    end else begin
      if (w_swap_st) begin
        r_bank <= ~r_bank;
        r_busy <= 1'b0;
      end else if (i_cfg_swap) begin
        r_busy <= 1'b1;
      end
      if (w_acc) r_p <= r_p + 5'd1;
      if (w_acc & w_lastp) r_blk <= r_blk + BLK_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_c0   <= '0;
      r_c1   <= '0;
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
      r_vld  <= 1'b0;
    end else if (w_acc) begin
      r_c0   <= i_c0;
      r_c1   <= i_c1;
      r_sh0  <= w_sh0;
      r_sh1  <= w_sh1;
      r_idx  <= w_i0;
      r_last <= w_lastp;
      r_vld  <= 1'b1;
    end else if (i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

`ifdef QUANT_SCHED_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_stall <= '0;
    else if (r_vld & ~i_rdy & (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign o_stall_cnt = r_stall;
`endif

  assign o_rdy      = w_rdy;
  assign o_c0       = r_c0;
  assign o_c1       = r_c1;
  assign o_sh0      = r_sh0;
  assign o_sh1      = r_sh1;
  assign o_idx      = r_idx;
  assign o_last     = r_last;
  assign o_vld      = r_vld;
  assign o_cfg_busy = r_busy;
  assign o_bank     = r_bank;
  assign o_blk_cnt  = r_blk;

endmodule

// File: tb/tb_quant_sched.sv
// tb_quant_sched: directed checks of sequencing, table swap, backpressure, reset and block-count wrap.
// The block counter is built 3 bits wide so its wrap is reached in a few hundred cycles.
module tb_quant_sched;

  localparam int DW  = 25;
  localparam int SW  = 5;
  localparam int BCW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [DW-1:0]  i_c0, i_c1;
  logic                  i_vld, o_rdy;
  logic signed [DW-1:0]  o_c0, o_c1;
  logic [SW-1:0]         o_sh0, o_sh1;
  logic [5:0]            o_idx;
  logic                  o_last, o_vld, i_rdy;
  logic                  we;
  logic [5:0]            addr;
  logic [SW-1:0]         wdat;
  logic                  swp;
  logic                  o_busy, o_bank;
  logic [BCW-1:0]        o_blk;
`ifdef QUANT_SCHED_PERF_EN
  logic [15:0]           o_stall;
`endif

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  quant_sched #(
    .DATA_WIDTH(DW), .SHIFT_WIDTH(SW),
    .DEFAULT_SHIFT(18), .BLK_CNT_WIDTH(BCW)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_c0(i_c0), .i_c1(i_c1),
    .i_vld(i_vld), .o_rdy(o_rdy),
    .o_c0(o_c0), .o_c1(o_c1),
    .o_sh0(o_sh0), .o_sh1(o_sh1),
    .o_idx(o_idx), .o_last(o_last),
    .o_vld(o_vld), .i_rdy(i_rdy),
    .i_cfg_we(we), .i_cfg_addr(addr),
    .i_cfg_data(wdat), .i_cfg_swap(swp),
    .o_cfg_busy(o_busy), .o_bank(o_bank),
`ifdef QUANT_SCHED_PERF_EN
    .o_stall_cnt(o_stall),
`endif
    .o_blk_cnt(o_blk)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_vld = 1'b0; i_rdy = 1'b1;
    i_c0 = '0; i_c1 = '0;
    we = 1'b0; addr = '0; wdat = '0; swp = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL rst_vld got %0d exp 0", o_vld); end
    ncmp++; if (o_last !== 1'b0) begin nerr++; $display("FAIL rst_last got %0d exp 0", o_last); end
    ncmp++; if (o_idx !== 6'd0) begin nerr++; $display("FAIL rst_idx got %0d exp 0", o_idx); end
    ncmp++; if (o_sh0 !== 5'd0 || o_sh1 !== 5'd0) begin nerr++; $display("FAIL rst_sh got %0d/%0d exp 0/0", o_sh0, o_sh1); end
    ncmp++; if (o_c0 !== '0 || o_c1 !== '0) begin nerr++; $display("FAIL rst_c got %0d/%0d exp 0/0", o_c0, o_c1); end
    ncmp++; if (o_bank !== 1'b0) begin nerr++; $display("FAIL rst_bank got %0d exp 0", o_bank); end
    ncmp++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %0d exp 0", o_busy); end
    ncmp++; if (o_blk !== 3'd0) begin nerr++; $display("FAIL rst_blk got %0d exp 0", o_blk); end
    ncmp++; if (o_rdy !== 1'b1) begin nerr++; $display("FAIL rst_rdy got %0d exp 1", o_rdy); end
`ifdef QUANT_SCHED_PERF_EN
    ncmp++; if (o_stall !== 16'd0) begin nerr++; $display("FAIL rst_stall got %0d exp 0", o_stall); end
`endif
  endtask

  task automatic test_block;
    i_c0 = 25'sd0; i_c1 = 25'sd1; i_vld = 1'b1;
    #1;
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL blk_pre_vld got %0d exp 0", o_vld); end
    for (int n = 0; n < 32; n++) begin
      i_c0 = DW'(2 * n); i_c1 = DW'(2 * n + 1); i_vld = 1'b1;
      tick;
      ncmp++; if (o_vld !== 1'b1) begin nerr++; $display("FAIL blk_vld n=%0d got %0d exp 1", n, o_vld); end
      ncmp++; if (o_idx !== 6'(2 * n)) begin nerr++; $display("FAIL blk_idx n=%0d got %0d exp %0d", n, o_idx, 2 * n); end
      ncmp++; if (o_c0 !== DW'(2 * n) || o_c1 !== DW'(2 * n + 1)) begin nerr++; $display("FAIL blk_data n=%0d got %0d/%0d exp %0d/%0d", n, o_c0, o_c1, 2 * n, 2 * n + 1); end
      ncmp++; if (o_sh0 !== 5'd18 || o_sh1 !== 5'd18) begin nerr++; $display("FAIL blk_sh n=%0d got %0d/%0d exp 18/18", n, o_sh0, o_sh1); end
      ncmp++; if (o_last !== (n == 31)) begin nerr++; $display("FAIL blk_last n=%0d got %0d exp %0d", n, o_last, n == 31); end
    end
    i_vld = 1'b0;
    ncmp++; if (o_blk !== 3'd1) begin nerr++; $display("FAIL blk_cnt got %0d exp 1", o_blk); end
    tick;
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL blk_drain_vld got %0d exp 0", o_vld); end
  endtask

  task automatic test_swap_idle;
    we = 1'b1; addr = 6'd0; wdat = 5'd3;
    tick;
    addr = 6'd1; wdat = 5'd4;
    tick;
    we = 1'b0; swp = 1'b1;
    tick;
    swp = 1'b0; i_c0 = 25'sd100; i_c1 = 25'sd101; i_vld = 1'b1;
    #1;
    ncmp++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL swi_busy got %0d exp 1", o_busy); end
    ncmp++; if (o_rdy !== 1'b0) begin nerr++; $display("FAIL swi_rdy got %0d exp 0", o_rdy); end
    ncmp++; if (o_bank !== 1'b0) begin nerr++; $display("FAIL swi_bank_pre got %0d exp 0", o_bank); end
    tick;
    ncmp++; if (o_bank !== 1'b1) begin nerr++; $display("FAIL swi_bank got %0d exp 1", o_bank); end
    ncmp++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL swi_busy_clr got %0d exp 0", o_busy); end
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL swi_noacc got %0d exp 0", o_vld); end
    tick;
    ncmp++; if (o_vld !== 1'b1 || o_idx !== 6'd0 || o_c0 !== 25'sd100) begin nerr++; $display("FAIL swi_first got vld=%0d idx=%0d c0=%0d exp 1/0/100", o_vld, o_idx, o_c0); end
    ncmp++; if (o_sh0 !== 5'd3 || o_sh1 !== 5'd4) begin nerr++; $display("FAIL swi_sh got %0d/%0d exp 3/4", o_sh0, o_sh1); end
  endtask

  task automatic test_swap_mid;
    for (int n = 1; n < 32; n++) begin
      i_c0 = DW'(2 * n); i_c1 = DW'(2 * n + 1); i_vld = 1'b1;
      we = 1'b0; swp = 1'b0;
      if (n == 5)  begin we = 1'b1; addr = 6'd0;  wdat = 5'd7;  end
      if (n == 6)  begin we = 1'b1; addr = 6'd40; wdat = 5'd11; end
      if (n == 10) swp = 1'b1;
      if (n == 12) begin we = 1'b1; addr = 6'd1;  wdat = 5'd9;  end
      tick;
      ncmp++; if (o_idx !== 6'(2 * n)) begin nerr++; $display("FAIL swm_idx n=%0d got %0d exp %0d", n, o_idx, 2 * n); end
      ncmp++; if (o_sh0 !== 5'd18 || o_sh1 !== 5'd18) begin nerr++; $display("FAIL swm_sh n=%0d got %0d/%0d exp 18/18", n, o_sh0, o_sh1); end
      ncmp++; if (o_busy !== (n >= 10)) begin nerr++; $display("FAIL swm_busy n=%0d got %0d exp %0d", n, o_busy, n >= 10); end
    end
    we = 1'b0; swp = 1'b0;
    i_c0 = 25'sd200; i_c1 = 25'sd201; i_vld = 1'b1;
    #1;
    ncmp++; if (o_rdy !== 1'b0) begin nerr++; $display("FAIL swm_rdy got %0d exp 0", o_rdy); end
    ncmp++; if (o_blk !== 3'd2) begin nerr++; $display("FAIL swm_blk got %0d exp 2", o_blk); end
    tick;
    ncmp++; if (o_bank !== 1'b0 || o_busy !== 1'b0) begin nerr++; $display("FAIL swm_bank got bank=%0d busy=%0d exp 0/0", o_bank, o_busy); end
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL swm_noacc got %0d exp 0", o_vld); end
    tick;
    ncmp++; if (o_idx !== 6'd0 || o_c0 !== 25'sd200) begin nerr++; $display("FAIL swm_first got idx=%0d c0=%0d exp 0/200", o_idx, o_c0); end
    ncmp++; if (o_sh0 !== 5'd7 || o_sh1 !== 5'd18) begin nerr++; $display("FAIL swm_newsh got %0d/%0d exp 7/18", o_sh0, o_sh1); end
  endtask

  task automatic test_reset_mid;
    for (int n = 1; n <= 20; n++) begin
      i_c0 = DW'(2 * n); i_c1 = DW'(2 * n + 1); i_vld = 1'b1;
      tick;
      ncmp++; if (o_idx !== 6'(2 * n)) begin nerr++; $display("FAIL rsm_idx n=%0d got %0d exp %0d", n, o_idx, 2 * n); end
      ncmp++; if (o_sh0 !== ((n == 20) ? 5'd11 : 5'd18) || o_sh1 !== 5'd18) begin nerr++; $display("FAIL rsm_sh n=%0d got %0d/%0d exp %0d/18", n, o_sh0, o_sh1, (n == 20) ? 11 : 18); end
    end
    rst = 1'b1; i_vld = 1'b0;
    tick;
    rst = 1'b0;
    ncmp++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL rsm_vld got %0d exp 0", o_vld); end
    ncmp++; if (o_bank !== 1'b0 || o_blk !== 3'd0) begin nerr++; $display("FAIL rsm_state got bank=%0d blk=%0d exp 0/0", o_bank, o_blk); end
    i_c0 = 25'sd300; i_c1 = 25'sd301; i_vld = 1'b1;
    tick;
    ncmp++; if (o_idx !== 6'd0 || o_c0 !== 25'sd300) begin nerr++; $display("FAIL rsm_first got idx=%0d c0=%0d exp 0/300", o_idx, o_c0); end
    ncmp++; if (o_sh0 !== 5'd18 || o_sh1 !== 5'd18) begin nerr++; $display("FAIL rsm_sh got %0d/%0d exp 18/18", o_sh0, o_sh1); end
  endtask

  task automatic test_stall;
    for (int n = 1; n <= 8; n++) begin
      i_c0 = DW'(2 * n); i_c1 = DW'(2 * n + 1); i_vld = 1'b1;
      if (n == 4) begin
        i_rdy = 1'b0;
        #1;
        ncmp++; if (o_rdy !== 1'b0) begin nerr++; $display("FAIL stl_rdy got %0d exp 0", o_rdy); end
        repeat (5) begin
          tick;
          ncmp++; if (o_vld !== 1'b1 || o_idx !== 6'd6 || o_c0 !== 25'sd6 || o_c1 !== 25'sd7) begin nerr++; $display("FAIL stl_hold got vld=%0d idx=%0d c0=%0d exp 1/6/6", o_vld, o_idx, o_c0); end
        end
        i_rdy = 1'b1;
        #1;
        ncmp++; if (o_rdy !== 1'b1) begin nerr++; $display("FAIL stl_rdy_back got %0d exp 1", o_rdy); end
`ifdef QUANT_SCHED_PERF_EN
        ncmp++; if (o_stall !== 16'd5) begin nerr++; $display("FAIL stl_cnt got %0d exp 5", o_stall); end
`endif
      end
      tick;
      ncmp++; if (o_idx !== 6'(2 * n) || o_c0 !== DW'(2 * n)) begin nerr++; $display("FAIL stl_seq n=%0d got idx=%0d c0=%0d exp %0d", n, o_idx, o_c0, 2 * n); end
    end
  endtask

  task automatic test_wrap;
    int pp = 9;
    int blocks = 0;
    while (blocks < 8) begin
      i_c0 = DW'(2 * pp); i_c1 = DW'(2 * pp + 1); i_vld = 1'b1;
      swp = (blocks == 7 && pp == 31);
      tick;
      ncmp++; if (o_idx !== 6'(2 * pp)) begin nerr++; $display("FAIL wrp_idx p=%0d got %0d exp %0d", pp, o_idx, 2 * pp); end
      if (pp == 31) begin
        blocks++;
        ncmp++; if (o_blk !== BCW'(blocks)) begin nerr++; $display("FAIL wrp_blk b=%0d got %0d exp %0d", blocks, o_blk, blocks % 8); end
      end
      pp = (pp + 1) % 32;
    end
    swp = 1'b0;
    #1;
    ncmp++; if (o_busy !== 1'b1 || o_rdy !== 1'b0) begin nerr++; $display("FAIL wrp_lastswap got busy=%0d rdy=%0d exp 1/0", o_busy, o_rdy); end
    i_vld = 1'b0;
    tick;
    ncmp++; if (o_bank !== 1'b1 || o_busy !== 1'b0) begin nerr++; $display("FAIL wrp_bank got bank=%0d busy=%0d exp 1/0", o_bank, o_busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_block;
    test_swap_idle;
    test_swap_mid;
    test_reset_mid;
    test_stall;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
